rotator_addr_gen: RTL

- Parametrised twiddle-address and control generator for one radix-2 SDF FFT stage.
- Counts accepted samples within an N-point frame.
- Drives the shared N/2-entry twiddle ROM address with stage-correct stride.
- Emits butterfly select, conjugate (IFFT) flag, valid and frame-done, delay-matched to the ROM read latency.
- Sits between the stage input valid path and the rotator ROM and complex multiplier of each pipeline stage.

---
 rtl/rotator_addr_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/rotator_addr_gen.sv
// Twiddle-address and control generator for one radix-2 SDF FFT stage.
// Address is registered once; control sideband is further delayed to line up with ROM data.
module rotator_addr_gen #(
  parameter int LOG2N       = 10,
  parameter int LAYER       = 5,
  parameter int ADDR_W      = 13,
  parameter int ROM_LAT     = 2,
  parameter int CLR_ON_IDLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              frame_start,
  input  logic              inverse,
  output logic [ADDR_W-1:0] rot_addr,
  output logic              rot_en,
  output logic              select,
  output logic              conj,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int SHIFT = LOG2N - LAYER;

  typedef struct packed {
    logic sel;
    logic conj;
    logic vld;
    logic done;
  } slot_t;

  logic [LOG2N-1:0]  cnt_q, cnt_d;
  logic [LOG2N-1:0]  idx_p0;
  logic              start_p0;
  logic              sel_p0;
  logic              done_p0;
  logic              conj_q, conj_d;
  logic [ADDR_W-1:0] rot_addr_q, rot_addr_d;
  logic              rot_en_q, rot_en_d;
  slot_t             slot_d;
  slot_t             dly_q [ROM_LAT+1];

  // p0: sample index, frame counter and conjugate latch
  always_comb begin
    start_p0 = in_valid & frame_start;
    idx_p0   = start_p0 ? '0 : cnt_q;
    sel_p0   = idx_p0[LAYER-1];
    done_p0  = in_valid & (&idx_p0);
    // the frame-start sample must already carry the newly sampled mode
    conj_d   = start_p0 ? inverse : conj_q;

    if (in_valid) begin
      cnt_d = idx_p0 + LOG2N'(1);
    end else if (CLR_ON_IDLE != 0) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q;
    end

    // lower half of each 2^LAYER span is unrotated; upper half steps W_(2^LAYER)^k
    rot_en_d   = in_valid & sel_p0;
    rot_addr_d = sel_p0 ? (ADDR_W'(idx_p0[LAYER-2:0]) << SHIFT) : '0;

    slot_d      = '0;
    slot_d.sel  = sel_p0;
    slot_d.conj = conj_d;
    slot_d.vld  = in_valid;
    slot_d.done = done_p0;
  end

  // p1: address stage; dly_q[1..ROM_LAT] track the ROM read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      conj_q     <= 1'b0;
      rot_addr_q <= '0;
      rot_en_q   <= 1'b0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      conj_q     <= conj_d;
      rot_addr_q <= rot_addr_d;
      rot_en_q   <= rot_en_d;
      dly_q[0]   <= slot_d;
      for (int i = 1; i <= ROM_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign rot_addr   = rot_addr_q;
  assign rot_en     = rot_en_q;
  assign select     = dly_q[ROM_LAT].sel;
  assign conj       = dly_q[ROM_LAT].conj;
  assign out_valid  = dly_q[ROM_LAT].vld;
  assign frame_done = dly_q[ROM_LAT].done;

endmodule
